data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h10010000: byte address of word 0.
REQ-002 Parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two.
REQ-003 Parameter WAIT_STATES, default 2: extra cycles inserted before response; range 0..15.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-006 MemRead  input  1  read request, level-sensitive.
REQ-007 MemWrite  input  1  write request, level-sensitive.
REQ-008 dAddress  input  32  byte address of access.
REQ-009 dWriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 ld_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-012 dReadData  output  32  load result, extended to 32 bits.
REQ-013 ready  output  1  one-cycle completion pulse.
REQ-014 err  output  1  access fault; valid only while ready=1.

Function
REQ-015 FSM states: IDLE, WAIT, DONE; all other encodings return to IDLE next cycle.
REQ-016 IDLE: if MemRead or MemWrite is sampled high, latch dAddress, dWriteData, size, ld_unsigned, and op; go to WAIT if WAIT_STATES>0 and the access is legal, else go to DONE.
REQ-017 WAIT: 4-bit counter loaded with WAIT_STATES-1 on entry; decrement each cycle; go to DONE on the cycle it reads 0.
REQ-018 DONE: ready=1 for exactly one cycle; unconditional return to IDLE.
REQ-019 Latency: request sampled at edge N -> ready high in cycle N+1+WAIT_STATES for a legal access; N+1 for a faulting access.
REQ-020 Request inputs are ignored in WAIT and DONE; latched values hold until the next acceptance.
REQ-021 Requester deasserts its request in the ready cycle; a request still high in IDLE after DONE is treated as a new request.
REQ-022 Fault (err=1 with ready) on any of:
- MemRead and MemWrite both high
- size=11
- halfword address[0]!=0
- word address[1:0]!=0
- address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1]
REQ-023 A faulting write does not modify memory.
REQ-024 A faulting read returns dReadData=32'h0.
REQ-025 Word index = (address-BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; lane = address[1:0], little-endian.
REQ-026 Write: only the addressed byte lanes are updated (byte: 1 lane; half: lanes 0-1 or 2-3; word: all lanes), on the edge entering DONE.
REQ-027 Read: the word is fetched on the edge entering DONE; the selected lane(s) are extended per ld_unsigned; dReadData holds until the next accepted read completes.
REQ-028 A write or faulting access leaves dReadData unchanged, except REQ-024.
REQ-029 Write followed by a read of the same address returns the new data; no forwarding hazard, since accesses are serialized.

Reset
REQ-030 rst=0 at a rising edge: state=IDLE, counter=0, ready=0, err=0, dReadData=32'h0, latched request cleared.
REQ-031 Reset mid-WAIT abandons the access: no memory write, no ready pulse.
REQ-032 Memory array contents are not reset; reads of never-written locations return an undefined value.
REQ-033 Requests are ignored while rst=0; the first request can be accepted at the first edge with rst=1.

Verification
REQ-034 Word store/load: WAIT_STATES=2; write 32'hDEADBEEF at 32'h10010004 (size=10); then read it -> ready 3 cycles after each acceptance, err=0, dReadData=32'hDEADBEEF.
REQ-035 Byte lanes: over 32'h11223344 at 32'h10010008, byte-write 8'hF0 to 32'h1001000B; then:
- signed byte read of 32'h1001000B -> 32'hFFFFFFF0
- unsigned byte read -> 32'h000000F0
- word read -> 32'hF0223344
REQ-036 Half sign extension: half-write 16'h8001 to 32'h10010012; then signed half read -> 32'hFFFF8001, unsigned half read -> 32'h00008001.
REQ-037 Faults: each case below -> ready+err one cycle after acceptance, memory unchanged:
- word read at 32'h10010006
- write at 32'h10011000 (DEPTH_WORDS=1024)
- size=11
- MemRead=MemWrite=1
REQ-038 Reset mid-operation: word write of 32'hCAFEF00D at 32'h10010010; pull rst low during WAIT -> no ready pulse, location keeps its prior value, dReadData=0 after reset.
REQ-039 WAIT_STATES=0 with back-to-back requests held high: ready in every second cycle, each access completes correctly.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte/half/word loads and stores into an on-chip word
// array, with programmable wait states, alignment/range fault detection and a ready pulse.
module data_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic [1:0]  size,
  input  logic        ld_unsigned,
  output logic [31:0] dReadData,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_WAIT = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic          idle;
  logic [31:0]   eff_addr, eff_wdata, offset;
  logic [1:0]    eff_size, lane;
  logic          eff_uns, eff_rd, eff_wr;
  logic          fault, access, mem_we;
  logic [AW-1:0] word_idx;
  logic [31:0]   mem_word, load_val, wr_word;
  logic [3:0]    wr_be;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  // In IDLE the access acts on the live inputs (zero-wait or faulting requests
  // complete on the accepting edge); afterwards it acts on the latched copy.
  always_comb begin
    idle      = (state_q == S_IDLE);
    eff_addr  = idle ? dAddress    : addr_q;
    eff_wdata = idle ? dWriteData  : wdata_q;
    eff_size  = idle ? size        : size_q;
    eff_uns   = idle ? ld_unsigned : uns_q;
    eff_rd    = idle ? MemRead     : rd_q;
    eff_wr    = idle ? MemWrite    : wr_q;
    offset    = eff_addr - BASE_ADDR;
    word_idx  = offset[AW+1:2];
    lane      = eff_addr[1:0];
    // An address below the base wraps to a huge offset, so one compare covers both bounds.
    fault     = (eff_rd & eff_wr)
              | (eff_size == 2'b11)
              | ((eff_size == SZ_HALF) & eff_addr[0])
              | ((eff_size == SZ_WORD) & (|eff_addr[1:0]))
              | (offset >= MEM_BYTES);
  end

  always_comb begin
    mem_word = mem[word_idx];
    ld_byte  = mem_word[8*lane +: 8];
    ld_half  = lane[1] ? mem_word[31:16] : mem_word[15:0];
    load_val = '0;
    wr_be    = 4'b0000;
    wr_word  = eff_wdata;
    case (eff_size)
      SZ_BYTE: begin
        load_val = eff_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        wr_be    = 4'b0001 << lane;
        wr_word  = {4{eff_wdata[7:0]}};
      end
      SZ_HALF: begin
        load_val = eff_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
        wr_be    = lane[1] ? 4'b1100 : 4'b0011;
        wr_word  = {2{eff_wdata[15:0]}};
      end
      SZ_WORD: begin
        load_val = mem_word;
        wr_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    uns_d   = uns_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = dAddress;
          wdata_d = dWriteData;
          size_d  = size;
          uns_d   = ld_unsigned;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          err_d   = fault;
          if (!fault && (WAIT_STATES > 0)) begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = S_DONE;
            access  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (access && eff_rd) begin
      rdata_d = fault ? 32'h0 : load_val;
    end
  end

  // A reset landing on the completing edge must abandon the store as well.
  assign mem_we = access & eff_wr & ~fault & rst;

  // NOTE: the array is deliberately left out of reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready     = (state_q == S_DONE);
  assign err       = ready & err_q;
  assign dReadData = rdata_q;

endmodule
